// File: rtl/id_ex_stage_pkg.sv
// Shared ALU encodings for the MIPS pipeline: the ALU Mod codes, alu_op classes and
// the R-type funct values that the decode and the ALU must agree on.
package id_ex_stage_pkg;

    typedef enum logic [2:0] {
        MOD_AND = 3'b000,
        MOD_OR  = 3'b001,
        MOD_SLT = 3'b011,
        MOD_ADD = 3'b100,
        MOD_SUB = 3'b110
    } mod_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_OR    = 2'b11
    } alu_op_e;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_alu_ctrl_dec.sv
// Combinational alu_op/funct to ALU Mod decode; unsupported R-type functs fall back
// to add and raise illegal.
module alu_ctrl_dec
    import id_ex_stage_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [5:0] i_funct,
    output mod_e       o_mod,
    output logic       o_illegal
);

    always_comb begin
        o_mod     = MOD_ADD;
        o_illegal = 1'b0;
        case (i_alu_op)
            ALUOP_ADD: o_mod = MOD_ADD;
            ALUOP_SUB: o_mod = MOD_SUB;
            ALUOP_OR:  o_mod = MOD_OR;
            default: begin
                case (i_funct)
                    FN_ADD, FN_ADDU: o_mod = MOD_ADD;
                    FN_SUB, FN_SUBU: o_mod = MOD_SUB;
                    FN_AND:          o_mod = MOD_AND;
                    FN_OR:           o_mod = MOD_OR;
                    FN_SLT:          o_mod = MOD_SLT;
                    default: begin
                        o_mod     = MOD_ADD;
                        o_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded fields, decodes the ALU Mod, forwards
// EX/MEM and MEM/WB results onto the operands, and bubbles on load-use hazards.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [W-1:0]  id_pc,
    input  logic [W-1:0]  id_rs_data,
    input  logic [W-1:0]  id_rt_data,
    input  logic [W-1:0]  id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [5:0]    id_funct,
    input  logic [1:0]    id_alu_op,
    input  logic          id_alu_src,
    input  logic          id_reg_dst,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          stall,
    input  logic          flush,
    input  logic          mem_reg_write,
    input  logic [RW-1:0] mem_rd,
    input  logic [W-1:0]  mem_result,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_rd,
    input  logic [W-1:0]  wb_result,
    output logic          lu_hazard,
    output logic          ex_valid,
    output logic [W-1:0]  ex_pc,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [2:0]    alu_mod,
    output logic [W-1:0]  ex_store_data,
    output logic [RW-1:0] ex_dest,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg,
    output logic          ex_illegal
);

    typedef struct packed {
        logic          valid;
        logic [W-1:0]  pc;
        logic [W-1:0]  rs_data;
        logic [W-1:0]  rt_data;
        logic [W-1:0]  imm;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] dest;
        ctrl_t         ctrl;
        logic [2:0]    mod;
        logic          illegal;
    } stage_t;

    // A bubble is all-zero except for the add Mod, which is also the reset state.
    localparam stage_t BUBBLE = stage_t'({{($bits(stage_t) - 4){1'b0}}, MOD_ADD, 1'b0});

    stage_t       r_ex;
    stage_t       w_id;
    mod_e         w_mod;
    logic         w_illegal;
    logic [W-1:0] w_fwd_rs;
    logic [W-1:0] w_fwd_rt;

    alu_ctrl_dec u_dec (
        .i_alu_op  (id_alu_op),
        .i_funct   (id_funct),
        .o_mod     (w_mod),
        .o_illegal (w_illegal)
    );

    always_comb begin
        w_id                 = BUBBLE;
        w_id.valid           = id_valid;
        w_id.pc              = id_pc;
        w_id.rs_data         = id_rs_data;
        w_id.rt_data         = id_rt_data;
        w_id.imm             = id_imm;
        w_id.rs              = id_rs;
        w_id.rt              = id_rt;
        w_id.dest            = id_reg_dst ? id_rd : id_rt;
        w_id.ctrl.reg_write  = id_reg_write;
        w_id.ctrl.mem_read   = id_mem_read;
        w_id.ctrl.mem_write  = id_mem_write;
        w_id.ctrl.mem_to_reg = id_mem_to_reg;
        w_id.ctrl.alu_src    = id_alu_src;
        w_id.mod             = w_mod;
        w_id.illegal         = w_illegal & id_valid;
    end

    // Checked even when id_valid is low: stalling behind a bubble costs nothing.
    assign lu_hazard = r_ex.valid & r_ex.ctrl.mem_read & (r_ex.rt != '0) &
                       ((r_ex.rt == id_rs) | (r_ex.rt == id_rt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex <= BUBBLE;
        end else if (flush || (!stall && lu_hazard)) begin
            r_ex <= BUBBLE;
        end else if (!stall) begin
            r_ex <= w_id;
        end
    end

    // EX/MEM beats MEM/WB since it is the younger result; $0 is never forwarded.
    assign w_fwd_rs = (mem_reg_write && (mem_rd != '0) && (mem_rd == r_ex.rs)) ? mem_result :
                      (wb_reg_write  && (wb_rd  != '0) && (wb_rd  == r_ex.rs)) ? wb_result  :
                      r_ex.rs_data;
    assign w_fwd_rt = (mem_reg_write && (mem_rd != '0) && (mem_rd == r_ex.rt)) ? mem_result :
                      (wb_reg_write  && (wb_rd  != '0) && (wb_rd  == r_ex.rt)) ? wb_result  :
                      r_ex.rt_data;

    assign alu_a         = w_fwd_rs;
    assign alu_b         = r_ex.ctrl.alu_src ? r_ex.imm : w_fwd_rt;
    assign ex_store_data = w_fwd_rt;
    assign alu_mod       = r_ex.mod;
    assign ex_valid      = r_ex.valid;
    assign ex_pc         = r_ex.pc;
    assign ex_dest       = r_ex.dest;
    assign ex_reg_write  = r_ex.ctrl.reg_write;
    assign ex_mem_read   = r_ex.ctrl.mem_read;
    assign ex_mem_write  = r_ex.ctrl.mem_write;
    assign ex_mem_to_reg = r_ex.ctrl.mem_to_reg;
    assign ex_illegal    = r_ex.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: stimulus queues hand-computed expectations stamped
// with a cycle number, a negedge monitor pops and compares them.
module tb_id_ex_stage;

    logic        clk, rst;
    logic        id_valid;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_funct;
    logic [1:0]  id_alu_op;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        stall, flush;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_result;
    logic        lu_hazard, ex_valid;
    logic [31:0] ex_pc, alu_a, alu_b, ex_store_data;
    logic [2:0]  alu_mod;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal;

    id_ex_stage #(.W(32), .RW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .stall(stall), .flush(flush), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_result(wb_result), .lu_hazard(lu_hazard), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .alu_a(alu_a), .alu_b(alu_b), .alu_mod(alu_mod),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_illegal(ex_illegal)
    );

    typedef struct packed {
        logic        v;
        logic [31:0] pc, a, b, sd;
        logic [2:0]  mod;
        logic        ill;
        logic [4:0]  dest;
        logic        rw, mr, mw, m2r, lu;
    } obs_t;

    typedef struct {
        int    cyc;
        string name;
        obs_t  o;
    } ent_t;

    ent_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string fmt(input obs_t o);
        return $sformatf("v=%0b pc=%h a=%h b=%h sd=%h mod=%b ill=%b dest=%0d rw/mr/mw/m2r=%b%b%b%b lu=%b",
                         o.v, o.pc, o.a, o.b, o.sd, o.mod, o.ill, o.dest, o.rw, o.mr, o.mw, o.m2r, o.lu);
    endfunction

    always @(negedge clk) begin
        obs_t got;
        got = '{ex_valid, ex_pc, alu_a, alu_b, ex_store_data, alu_mod, ex_illegal, ex_dest,
                ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, lu_hazard};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            ent_t e;
            e = sb.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: expectation never sampled (cycle %0d, now %0d)", e.name, e.cyc, cyc);
            end else if (got !== e.o) begin
                errors++;
                $display("FAIL %s: got %s", e.name, fmt(got));
                $display("     %s: need %s", e.name, fmt(e.o));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [31:0] pc, input logic [4:0] rs, rt, rd,
                       input logic [31:0] rsd, rtd, imm, input logic [5:0] fn, input logic [1:0] op,
                       input logic src, dst, rw, mr, mw, m2r);
        id_valid = v; id_pc = pc; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_funct = fn; id_alu_op = op;
        id_alu_src = src; id_reg_dst = dst; id_reg_write = rw; id_mem_read = mr;
        id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    task automatic fwd(input logic mw, input logic [4:0] mrd, input logic [31:0] mres,
                       input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
        mem_reg_write = mw; mem_rd = mrd; mem_result = mres;
        wb_reg_write = ww; wb_rd = wrd; wb_result = wres;
    endtask

    task automatic chk(input string n, input logic v, input logic [31:0] pc, a, b, sd,
                       input logic [2:0] mod, input logic ill, input logic [4:0] dest,
                       input logic rw, mr, mw, m2r, lu);
        ent_t e;
        e.cyc  = cyc;
        e.name = n;
        e.o    = '{v, pc, a, b, sd, mod, ill, dest, rw, mr, mw, m2r, lu};
        sb.push_back(e);
    endtask

    task automatic chk_bubble(input string n);
        chk(n, 0, 0, 0, 0, 0, 3'b100, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 6'd0, 2'b00, 0, 0, 0, 0, 0, 0);
        fwd(0, 0, 0, 0, 0, 0);
        repeat (2) step();

        // add $3,$1,$2 presented as reset releases
        rst = 1'b0;
        drv(1, 32'h100, 1, 2, 3, 5, 7, 0, 6'b100000, 2'b10, 0, 1, 1, 0, 0, 0);
        chk_bubble("reset");
        step(); stall = 1'b1;
        chk("add", 1, 32'h100, 5, 7, 7, 3'b100, 0, 3, 1, 0, 0, 0, 0);
        step(); fwd(1, 1, 32'hAA, 1, 1, 32'hBB);
        chk("fwd_mem_over_wb", 1, 32'h100, 32'hAA, 7, 7, 3'b100, 0, 3, 1, 0, 0, 0, 0);
        step(); fwd(0, 1, 32'hAA, 1, 1, 32'hBB);
        chk("fwd_wb", 1, 32'h100, 32'hBB, 7, 7, 3'b100, 0, 3, 1, 0, 0, 0, 0);
        step(); fwd(1, 0, 32'hAA, 1, 2, 32'hBB);
        chk("fwd_memrd0_wb_rt", 1, 32'h100, 5, 32'hBB, 32'hBB, 3'b100, 0, 3, 1, 0, 0, 0, 0);

        // lw $4,0x10($5) then a consumer of $4
        step(); stall = 1'b0; fwd(0, 0, 0, 0, 0, 0);
        drv(1, 32'h104, 5, 4, 0, 32'h20, 0, 32'h10, 6'd0, 2'b00, 1, 0, 1, 1, 0, 1);
        chk("stall_held_add", 1, 32'h100, 5, 7, 7, 3'b100, 0, 3, 1, 0, 0, 0, 0);
        step();
        drv(1, 32'h108, 4, 7, 6, 9, 1, 0, 6'b100000, 2'b10, 0, 1, 1, 0, 0, 0);
        chk("lw_load_use", 1, 32'h104, 32'h20, 32'h10, 0, 3'b100, 0, 4, 1, 1, 0, 1, 1);
        step(); fwd(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
        chk_bubble("lu_bubble_r0_nofwd");
        step(); fwd(0, 0, 0, 0, 0, 0);
        drv(1, 32'h10C, 5, 0, 0, 32'h30, 0, 4, 6'd0, 2'b00, 1, 0, 1, 1, 0, 1);
        chk("consumer_after_bubble", 1, 32'h108, 9, 1, 1, 3'b100, 0, 6, 1, 0, 0, 0, 0);
        step();
        drv(1, 32'h110, 9, 0, 8, 20, 0, 0, 6'b100010, 2'b10, 0, 1, 1, 0, 0, 0);
        chk("lw_rt0_no_hazard", 1, 32'h10C, 32'h30, 4, 0, 3'b100, 0, 0, 1, 1, 0, 1, 0);

        // sub held by three stall cycles, then flush+stall squashes it
        step(); stall = 1'b1;
        drv(1, 32'h300, 1, 1, 1, 32'h99, 32'h99, 32'h99, 6'b100101, 2'b11, 1, 0, 0, 1, 1, 0);
        chk("sub", 1, 32'h110, 20, 0, 0, 3'b110, 0, 8, 1, 0, 0, 0, 0);
        step(); chk("sub_stall1", 1, 32'h110, 20, 0, 0, 3'b110, 0, 8, 1, 0, 0, 0, 0);
        step(); chk("sub_stall2", 1, 32'h110, 20, 0, 0, 3'b110, 0, 8, 1, 0, 0, 0, 0);
        step(); flush = 1'b1;
        chk("sub_stall3", 1, 32'h110, 20, 0, 0, 3'b110, 0, 8, 1, 0, 0, 0, 0);
        step(); stall = 1'b0; flush = 1'b0;
        drv(1, 32'h200, 1, 2, 5, 11, 12, 0, 6'b000000, 2'b10, 0, 1, 1, 0, 0, 0);
        chk_bubble("flush_beats_stall");

        // illegal funct, its bubble twin, then ori / sw / slt / and
        step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 2'b10, 0, 0, 0, 0, 0, 0);
        chk("illegal", 1, 32'h200, 11, 12, 12, 3'b100, 1, 5, 1, 0, 0, 0, 0);
        step();
        drv(1, 32'h204, 3, 7, 0, 32'hF, 32'h55, 32'h10, 6'd0, 2'b11, 1, 0, 1, 0, 0, 0);
        chk_bubble("illegal_when_invalid");
        step();
        drv(1, 32'h208, 2, 6, 0, 32'h40, 32'h77, 8, 6'd0, 2'b00, 1, 0, 0, 0, 1, 0);
        chk("ori_imm", 1, 32'h204, 32'hF, 32'h10, 32'h55, 3'b001, 0, 7, 1, 0, 0, 0, 0);
        step();
        drv(1, 32'h20C, 1, 2, 9, 1, 2, 0, 6'b101010, 2'b10, 0, 1, 1, 0, 0, 0);
        chk("sw", 1, 32'h208, 32'h40, 8, 32'h77, 3'b100, 0, 6, 0, 0, 1, 0, 0);
        step();
        drv(1, 32'h210, 1, 2, 10, 3, 5, 0, 6'b100100, 2'b10, 0, 1, 1, 0, 0, 0);
        chk("slt", 1, 32'h20C, 1, 2, 2, 3'b011, 0, 9, 1, 0, 0, 0, 0);
        step();
        drv(1, 32'h214, 1, 2, 11, 8, 3, 0, 6'b100010, 2'b10, 0, 1, 1, 0, 0, 0);
        chk("and", 1, 32'h210, 3, 5, 5, 3'b000, 0, 10, 1, 0, 0, 0, 0);

        // async reset mid-cycle with a valid sub registered and stall high
        step();
        chk_bubble("async_reset_midcycle");
        #2; rst = 1'b1; stall = 1'b1;
        step(); chk_bubble("reset_with_stall");
        step(); rst = 1'b0; stall = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 6'd0, 2'b00, 0, 0, 0, 0, 0, 0);
        chk_bubble("reset_release");
        repeat (2) step();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, need 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
